// File: rtl/queue_pkg.sv
// Shared sizing constants for the linear rewindable queue.
package queue_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_WIDTH = 2;

    // Pointers count 0..depth inclusive, so they need one bit beyond the index width.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/queue_2bit.sv
// Linear (non-wrapping) queue: entries are written once, read by an advancing
// front pointer that can be rewound to replay everything written so far.
module queue_2bit
    import queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_front,
    input  logic             enqueue,
    input  logic             dequeue,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             finish,
    output logic             full
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    front;
    logic [PW-1:0]    rear;

    // Request semantics: enqueue is accepted on any edge where full is low,
    // dequeue on any edge where finish is low; both judged on pre-edge
    // pointers, so an entry written this edge is never read past this edge.
    logic do_write;
    logic do_advance;

    assign full       = (rear == PW'(DEPTH));
    assign finish     = (front == rear);
    assign do_write   = enqueue && !full;
    assign do_advance = dequeue && !finish;

    assign data_out = (front == PW'(DEPTH)) ? '0 : mem[front[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            front <= '0;
            rear  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_write) begin
                mem[rear[AW-1:0]] <= data_in;
                rear              <= rear + PW'(1);
            end
            // Rewind wins over a same-cycle advance; memory is left intact.
            if (rst_front) begin
                front <= '0;
            end else if (do_advance) begin
                front <= front + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_queue_2bit.sv
// Directed bench for queue_2bit with a reference model feeding an expected-data queue.
module tb_queue_2bit;

    logic       clk;
    logic       rst;
    logic       rst_front;
    logic       enqueue;
    logic       dequeue;
    logic [1:0] data_in;
    logic [1:0] data_out;
    logic       finish;
    logic       full;

    int total;
    int bad;

    logic [1:0] exp_q[$];
    logic [1:0] m_mem [16];
    int         m_front;
    int         m_rear;

    queue_2bit dut (
        .clk       (clk),
        .rst       (rst),
        .rst_front (rst_front),
        .enqueue   (enqueue),
        .dequeue   (dequeue),
        .data_in   (data_in),
        .data_out  (data_out),
        .finish    (finish),
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_mem[i] = 2'd0;
        m_front = 0;
        m_rear  = 0;
        exp_q.delete();
    endtask

    task automatic check_outputs(input string tag);
        logic [1:0] e;
        e = exp_q.pop_front();
        check({tag, ".data_out"}, 32'(data_out), 32'(e));
        check({tag, ".finish"}, 32'(finish), 32'(m_front == m_rear));
        check({tag, ".full"}, 32'(full), 32'(m_rear == 16));
    endtask

    // One clock of stimulus: update the model on pre-edge state, push the
    // expected data_out, then compare shortly after the edge.
    task automatic step(input string tag, input logic enq, input logic deq,
                        input logic rf, input logic [1:0] din);
        bit m_fin;
        bit m_full;
        enqueue   = enq;
        dequeue   = deq;
        rst_front = rf;
        data_in   = din;
        m_fin  = (m_front == m_rear);
        m_full = (m_rear == 16);
        if (enq && !m_full) begin
            m_mem[m_rear] = din;
            m_rear++;
        end
        if (rf) m_front = 0;
        else if (deq && !m_fin) m_front++;
        exp_q.push_back(m_front == 16 ? 2'd0 : m_mem[m_front]);
        @(posedge clk);
        #1;
        enqueue   = 1'b0;
        dequeue   = 1'b0;
        rst_front = 1'b0;
        check_outputs(tag);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".data_out"}, 32'(data_out), 32'd0);
        check({tag, ".finish"}, 32'(finish), 32'd1);
        check({tag, ".full"}, 32'(full), 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        rst_front = 1'b0;
        enqueue   = 1'b0;
        dequeue   = 1'b0;
        data_in   = 2'd0;
        model_clear();

        #1;
        check_reset_state("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset_held");
        rst = 1'b1;

        step("deq_empty", 1'b0, 1'b1, 1'b0, 2'd0);

        for (int i = 0; i < 11; i++) step("fill11", 1'b1, 1'b0, 1'b0, 2'(i % 4));
        check("fill11.finish_low", 32'(finish), 32'd0);

        for (int i = 0; i < 18; i++) step("drain18", 1'b0, 1'b1, 1'b0, 2'd0);
        check("drain18.finish_high", 32'(finish), 32'd1);

        step("rewind", 1'b0, 1'b0, 1'b1, 2'd0);
        for (int i = 0; i < 12; i++) step("replay", 1'b0, 1'b1, 1'b0, 2'd0);

        step("rewind_vs_deq", 1'b0, 1'b1, 1'b1, 2'd0);
        step("enq_and_rewind", 1'b1, 1'b0, 1'b1, 2'd3);
        step("enq_and_deq", 1'b1, 1'b1, 1'b0, 2'd1);
        for (int i = 0; i < 4; i++) step("mid_deq", 1'b0, 1'b1, 1'b0, 2'd0);

        // Asynchronous reset between clock edges while dequeue is asserted.
        dequeue = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("reset_mid");
        model_clear();
        dequeue = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        step("same_cycle_empty", 1'b1, 1'b1, 1'b0, 2'd2);
        step("next_deq", 1'b0, 1'b1, 1'b0, 2'd0);
        rst = 1'b0;
        #1;
        model_clear();
        check_reset_state("reset_again");
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 16; i++) step("fill16", 1'b1, 1'b0, 1'b0, 2'(3 - (i % 4)));
        check("fill16.full", 32'(full), 32'd1);
        step("enq_when_full", 1'b1, 1'b0, 1'b0, 2'd1);
        for (int i = 0; i < 17; i++) step("drain16", 1'b0, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) step("rand_deq", 1'b0, 1'(($urandom_range(0, 1))), 1'b0, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/queue_2bit.md
QUEUE_2BIT -- requirements
Module: queue_2bit

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the number of storage entries (power of two, at least 2).
REQ-002 Parameter WIDTH, default 2, SHALL set the data width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 rst_front  input  1  SHALL be a synchronous request to rewind the read pointer to entry 0.
REQ-006 enqueue  input  1  SHALL be the write request.
REQ-007 dequeue  input  1  SHALL be the read-advance request.
REQ-008 data_in  input  WIDTH  SHALL be the write data.
REQ-009 data_out  output  WIDTH  SHALL be the entry at the read pointer.
REQ-010 finish  output  1  SHALL be high when the read pointer equals the write pointer (nothing left to read).
REQ-011 full  output  1  SHALL be high when all DEPTH entries have been written.

Function
REQ-012 The design SHALL hold a linear (non-wrapping) array of DEPTH entries plus two pointers.
- rear: write pointer, counts 0..DEPTH.
- front: read pointer, counts 0..rear.
- Each pointer is $clog2(DEPTH)+1 bits.
REQ-013 On a clock edge with enqueue=1 and full=0, the design SHALL write data_in to mem[rear] and increment rear by 1.
REQ-014 When full=1, enqueue SHALL be ignored: no write and no pointer change.
REQ-015 On a clock edge with dequeue=1 and finish=0, front SHALL increment by 1.
REQ-016 When finish=1, dequeue SHALL be ignored.
REQ-017 Dequeue SHALL NOT erase data; entries remain readable after a rewind.
REQ-018 data_out SHALL be combinational mem[front]; it SHALL be 0 when front==DEPTH.
REQ-019 data_out SHALL update in the same cycle that front changes, with no added latency.
REQ-020 finish SHALL be combinational (front==rear); full SHALL be combinational (rear==DEPTH).
REQ-021 On a clock edge with rst_front=1, front SHALL be set to 0.
- rst_front has priority over a simultaneous dequeue.
- rst_front SHALL NOT affect rear or memory contents.
REQ-022 When enqueue and dequeue are asserted in the same cycle, both SHALL take effect.
- finish SHALL be evaluated on the pre-edge pointers.
- A read of an entry written in that same cycle SHALL NOT occur.
REQ-023 Enqueue and rst_front asserted in the same cycle SHALL both take effect.

Reset
REQ-024 While rst=0, the design SHALL asynchronously clear front, rear and all memory entries to 0.
REQ-025 During reset the outputs SHALL be data_out=0, finish=1, full=0.
REQ-026 Reset asserted mid-operation SHALL discard all stored data; this reset SHALL take priority over every other input.

Structure
REQ-027 Default DEPTH and WIDTH constants SHALL reside in a shared package queue_pkg.
REQ-028 The pointer-width function or constant SHALL also reside in queue_pkg.
REQ-029 The block SHALL be a single module with no sub-modules; storage SHALL be a register array, not a memory macro.

Verification
REQ-030 Scenario: reset, then dequeue=1 for 1 cycle on an empty queue.
- Required: front stays 0, finish=1, data_out=0.
REQ-031 Scenario: enqueue data 0,1,2,3,0,1,2,3,0,1,2 (11 writes).
- Required: rear=11, full=0, finish=0, data_out=0.
REQ-032 Scenario: hold dequeue=1 for 18 cycles after the 11 writes.
- Required: data_out steps 0,1,2,3,0,1,2,3,0,1,2.
- Required: finish=1 after the 11th advance; front then stays at 11.
REQ-033 Scenario: pulse rst_front for 1 cycle, then dequeue again.
- Required: front=0 and data_out=0, then the same 11-value sequence replays.
REQ-034 Scenario: enqueue 16 values 3,2,1,0 repeated.
- Required: full=1 after the 16th write; a 17th enqueue with data_in=1 changes nothing.
REQ-035 Scenario: drive rst=0 asynchronously mid-dequeue.
- Required: front=rear=0, finish=1, full=0, data_out=0, all without waiting for a clock edge.
